// File: rtl/prio_pkg.sv
// Shared definitions for the registered priority / round-robin arbiter.
package prio_pkg;

  // Raw encodings of the mode input.
  localparam logic [1:0] MODE_FIX_HI = 2'b00;
  localparam logic [1:0] MODE_FIX_LO = 2'b01;
  localparam logic [1:0] MODE_RR     = 2'b10;

  // Decoded arbitration policy.
  typedef enum logic [1:0] {
    PolFixHi,
    PolFixLo,
    PolRr
  } policy_e;

  // Map the raw mode input onto a policy; the spare code 11 behaves as MSB-first.
  function automatic policy_e decode_mode(input logic [1:0] mode);
    policy_e pol;
    case (mode)
      MODE_FIX_LO: pol = PolFixLo;
      MODE_RR:     pol = PolRr;
      default:     pol = PolFixHi;
    endcase
    return pol;
  endfunction

endpackage

// File: rtl/prio_enc_core.sv
// Combinational winner selection: fixed MSB-first, fixed LSB-first, or an upward
// rotating scan from a start pointer with wrap at N-1.
module prio_enc_core
  import prio_pkg::*;
#(
  parameter int unsigned N = 8,
  parameter int unsigned M = $clog2(N)
) (
  input  logic [N-1:0] req,
  input  logic [1:0]   mode,
  input  logic [M-1:0] start,
  output logic [M-1:0] idx,
  output logic         any
);

  logic [M-1:0] hi_idx;
  logic [M-1:0] lo_idx;
  logic [M-1:0] masked_idx;
  logic [M-1:0] rr_idx;
  logic [N-1:0] mask;
  logic [N-1:0] masked;
  logic         masked_any;

  // Highest set index: later iterations overwrite earlier ones.
  always_comb begin
    hi_idx = '0;
    for (int i = 0; i < int'(N); i++) begin
      if (req[i]) hi_idx = M'(i);
    end
  end

  // Lowest set index: scan downward so the lowest hit is written last.
  always_comb begin
    lo_idx = '0;
    for (int i = int'(N) - 1; i >= 0; i--) begin
      if (req[i]) lo_idx = M'(i);
    end
  end

  // Keep only requesters at or above the start pointer.
  always_comb begin
    mask = '0;
    for (int i = 0; i < int'(N); i++) begin
      mask[i] = (i >= int'(start));
    end
  end

  assign masked     = req & mask;
  assign masked_any = |masked;

  // Lowest set index among the masked requesters.
  always_comb begin
    masked_idx = '0;
    for (int i = int'(N) - 1; i >= 0; i--) begin
      if (masked[i]) masked_idx = M'(i);
    end
  end

  // Double search: masked hit first, otherwise wrap to the lowest unmasked requester.
  assign rr_idx = masked_any ? masked_idx : lo_idx;
  assign any    = |req;

  // Policy mux.
  always_comb begin
    idx = hi_idx;
    unique case (decode_mode(mode))
      PolFixLo: idx = lo_idx;
      PolRr:    idx = rr_idx;
      default:  idx = hi_idx;
    endcase
  end

endmodule

// File: rtl/prio_arbiter_rr.sv
// Registered N-way arbiter with a valid/ready grant output and round-robin pointer.
module prio_arbiter_rr
  import prio_pkg::*;
#(
  parameter int unsigned N = 8,
  parameter int unsigned M = $clog2(N)
) (
  input  logic         clk,
  input  logic         rst,
  input  logic [N-1:0] req,
  input  logic [1:0]   mode,
  output logic         grant_valid,
  output logic [M-1:0] grant_idx,
  output logic [N-1:0] grant_onehot,
  input  logic         grant_ready
);

  logic         valid_q, valid_d;
  logic [M-1:0] idx_q, idx_d;
  logic [N-1:0] onehot_q, onehot_d;
  logic [M-1:0] rr_ptr_q, rr_ptr_d;
  logic         load;
  logic         xfer;
  logic [M-1:0] win_idx;
  logic         win_any;

  assign xfer = valid_q & grant_ready;
  assign load = ~valid_q | grant_ready;

  // Pointer advances past the grant leaving this cycle, wrapping at N-1.
  always_comb begin
    rr_ptr_d = rr_ptr_q;
    if (xfer && (mode == MODE_RR)) begin
      rr_ptr_d = (idx_q == M'(N - 1)) ? '0 : idx_q + M'(1);
    end
  end

  // Selection uses the updated pointer so the departing grant is excluded.
  prio_enc_core #(
    .N(N),
    .M(M)
  ) u_enc (
    .req  (req),
    .mode (mode),
    .start(rr_ptr_d),
    .idx  (win_idx),
    .any  (win_any)
  );

  // Output register next state: load a new winner or go idle, otherwise hold.
  always_comb begin
    valid_d  = valid_q;
    idx_d    = idx_q;
    onehot_d = onehot_q;
    if (load) begin
      if (win_any) begin
        valid_d           = 1'b1;
        idx_d             = win_idx;
        onehot_d          = '0;
        onehot_d[win_idx] = 1'b1;
      end else begin
        valid_d  = 1'b0;
        onehot_d = '0;
      end
    end
  end

  // State registers; reset beats any same-cycle transfer.
  always_ff @(posedge clk) begin
    if (rst) begin
      valid_q  <= 1'b0;
      idx_q    <= '0;
      onehot_q <= '0;
      rr_ptr_q <= '0;
    end else begin
      valid_q  <= valid_d;
      idx_q    <= idx_d;
      onehot_q <= onehot_d;
      rr_ptr_q <= rr_ptr_d;
    end
  end

  assign grant_valid  = valid_q;
  assign grant_idx    = idx_q;
  assign grant_onehot = onehot_q;

endmodule

// File: tb/tb_prio_arbiter_rr.sv
// Bench for prio_arbiter_rr: vector table on N=8, hand sequence and random model run on N=5.
module tb_prio_arbiter_rr;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  // N=8 instance
  logic       rst_a;
  logic [7:0] req_a;
  logic [1:0] mode_a;
  logic       rdy_a;
  logic       gv_a;
  logic [2:0] gi_a;
  logic [7:0] go_a;

  // N=5 instance
  logic       rst_b;
  logic [4:0] req_b;
  logic [1:0] mode_b;
  logic       rdy_b;
  logic       gv_b;
  logic [2:0] gi_b;
  logic [4:0] go_b;

  prio_arbiter_rr #(.N(8)) dut_a (
    .clk         (clk),
    .rst         (rst_a),
    .req         (req_a),
    .mode        (mode_a),
    .grant_valid (gv_a),
    .grant_idx   (gi_a),
    .grant_onehot(go_a),
    .grant_ready (rdy_a)
  );

  prio_arbiter_rr #(.N(5)) dut_b (
    .clk         (clk),
    .rst         (rst_b),
    .req         (req_b),
    .mode        (mode_b),
    .grant_valid (gv_b),
    .grant_idx   (gi_b),
    .grant_onehot(go_b),
    .grant_ready (rdy_b)
  );

  typedef struct {
    logic       rst;
    logic [7:0] req;
    logic [1:0] mode;
    logic       rdy;
    logic       v;
    logic [2:0] idx;
    logic [7:0] oh;
    logic [2:0] ptr;
  } vec_t;

  typedef struct {
    logic       v;
    logic [2:0] idx;
    logic [7:0] oh;
    logic [2:0] ptr;
    int         tag;
  } exp_t;

  vec_t vecs[32];
  exp_t sb[$];

  int n_checks = 0;
  int n_pass   = 0;

  task automatic chk(input string name, input int tag, input logic [31:0] act,
                     input logic [31:0] exp);
    n_checks++;
    if (act !== exp) $display("FAIL %s[%0d]: got %0h, want %0h", name, tag, act, exp);
    else n_pass++;
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Reference scan for N=5, written as a modulo walk rather than a masked search.
  function automatic int pick5(input logic [4:0] r, input logic [1:0] m, input int start);
    if (m == 2'b10) begin
      for (int k = 0; k < 5; k++) if (r[(start + k) % 5]) return (start + k) % 5;
    end else if (m == 2'b01) begin
      for (int j = 0; j < 5; j++) if (r[j]) return j;
    end else begin
      for (int j = 4; j >= 0; j--) if (r[j]) return j;
    end
    return -1;
  endfunction

  int   mv, midx, mptr;

  task automatic model5(input logic r_rst, input logic [4:0] r, input logic [1:0] m,
                        input logic rdy);
    int nptr, w;
    if (r_rst) begin
      mv = 0; midx = 0; mptr = 0;
    end else begin
      nptr = mptr;
      if (mv == 1 && rdy && m == 2'b10) nptr = (midx == 4) ? 0 : midx + 1;
      if (mv == 0 || rdy) begin
        w = pick5(r, m, nptr);
        if (w >= 0) begin mv = 1; midx = w; end
        else mv = 0;
      end
      mptr = nptr;
    end
  endtask

  initial begin
    exp_t e;
    //          rst   req    mode rdy  v     idx   oh     ptr
    vecs[0]  = '{1'b1, 8'hFF, 2'd0, 1'b1, 1'b0, 3'd0, 8'h00, 3'd0};
    vecs[1]  = '{1'b1, 8'hFF, 2'd0, 1'b1, 1'b0, 3'd0, 8'h00, 3'd0};
    vecs[2]  = '{1'b1, 8'hFF, 2'd0, 1'b1, 1'b0, 3'd0, 8'h00, 3'd0};
    vecs[3]  = '{1'b0, 8'hFF, 2'd0, 1'b1, 1'b1, 3'd7, 8'h80, 3'd0};
    vecs[4]  = '{1'b0, 8'h26, 2'd0, 1'b1, 1'b1, 3'd5, 8'h20, 3'd0};
    vecs[5]  = '{1'b0, 8'h26, 2'd1, 1'b1, 1'b1, 3'd1, 8'h02, 3'd0};
    vecs[6]  = '{1'b0, 8'h26, 2'd3, 1'b1, 1'b1, 3'd5, 8'h20, 3'd0};
    vecs[7]  = '{1'b0, 8'h00, 2'd0, 1'b1, 1'b0, 3'd5, 8'h00, 3'd0};
    vecs[8]  = '{1'b0, 8'hFF, 2'd2, 1'b1, 1'b1, 3'd0, 8'h01, 3'd0};
    vecs[9]  = '{1'b0, 8'hFF, 2'd2, 1'b1, 1'b1, 3'd1, 8'h02, 3'd1};
    vecs[10] = '{1'b0, 8'hFF, 2'd2, 1'b1, 1'b1, 3'd2, 8'h04, 3'd2};
    vecs[11] = '{1'b0, 8'hFF, 2'd2, 1'b1, 1'b1, 3'd3, 8'h08, 3'd3};
    vecs[12] = '{1'b0, 8'hFF, 2'd2, 1'b1, 1'b1, 3'd4, 8'h10, 3'd4};
    vecs[13] = '{1'b0, 8'hFF, 2'd2, 1'b1, 1'b1, 3'd5, 8'h20, 3'd5};
    vecs[14] = '{1'b0, 8'hFF, 2'd2, 1'b1, 1'b1, 3'd6, 8'h40, 3'd6};
    vecs[15] = '{1'b0, 8'hFF, 2'd2, 1'b1, 1'b1, 3'd7, 8'h80, 3'd7};
    vecs[16] = '{1'b0, 8'hFF, 2'd2, 1'b1, 1'b1, 3'd0, 8'h01, 3'd0};
    vecs[17] = '{1'b0, 8'h81, 2'd2, 1'b1, 1'b1, 3'd7, 8'h80, 3'd1};
    vecs[18] = '{1'b0, 8'h81, 2'd2, 1'b1, 1'b1, 3'd0, 8'h01, 3'd0};
    vecs[19] = '{1'b0, 8'h81, 2'd2, 1'b1, 1'b1, 3'd7, 8'h80, 3'd1};
    vecs[20] = '{1'b0, 8'h81, 2'd2, 1'b1, 1'b1, 3'd0, 8'h01, 3'd0};
    vecs[21] = '{1'b0, 8'h08, 2'd2, 1'b1, 1'b1, 3'd3, 8'h08, 3'd1};
    vecs[22] = '{1'b0, 8'h80, 2'd2, 1'b0, 1'b1, 3'd3, 8'h08, 3'd1};
    vecs[23] = '{1'b0, 8'h80, 2'd2, 1'b0, 1'b1, 3'd3, 8'h08, 3'd1};
    vecs[24] = '{1'b0, 8'h00, 2'd2, 1'b0, 1'b1, 3'd3, 8'h08, 3'd1};
    vecs[25] = '{1'b0, 8'h00, 2'd2, 1'b0, 1'b1, 3'd3, 8'h08, 3'd1};
    vecs[26] = '{1'b0, 8'h00, 2'd2, 1'b1, 1'b0, 3'd3, 8'h00, 3'd4};
    vecs[27] = '{1'b0, 8'h00, 2'd2, 1'b1, 1'b0, 3'd3, 8'h00, 3'd4};
    vecs[28] = '{1'b0, 8'h01, 2'd2, 1'b0, 1'b1, 3'd0, 8'h01, 3'd4};
    vecs[29] = '{1'b0, 8'h01, 2'd2, 1'b0, 1'b1, 3'd0, 8'h01, 3'd4};
    vecs[30] = '{1'b1, 8'h01, 2'd2, 1'b1, 1'b0, 3'd0, 8'h00, 3'd0};
    vecs[31] = '{1'b0, 8'h00, 2'd2, 1'b1, 1'b0, 3'd0, 8'h00, 3'd0};

    rst_b = 1'b1; req_b = '0; mode_b = 2'd0; rdy_b = 1'b0;

    // Table phase on N=8: drive, push expectation, compare after the edge.
    for (int i = 0; i < 32; i++) begin
      rst_a = vecs[i].rst; req_a = vecs[i].req; mode_a = vecs[i].mode; rdy_a = vecs[i].rdy;
      sb.push_back('{vecs[i].v, vecs[i].idx, vecs[i].oh, vecs[i].ptr, i});
      step();
      if (sb.size() == 0) begin
        chk("sb_empty", i, 32'd0, 32'd1);
      end else begin
        e = sb.pop_front();
        chk("valid", e.tag, 32'(gv_a), 32'(e.v));
        chk("idx", e.tag, 32'(gi_a), 32'(e.idx));
        chk("onehot", e.tag, 32'(go_a), 32'(e.oh));
        chk("rr_ptr", e.tag, 32'(dut_a.rr_ptr_q), 32'(e.ptr));
      end
    end

    // N=5 wrap: grant 4 must return the pointer to 0 and the next grant to 0.
    rst_a = 1'b1;
    step();
    rst_b = 1'b0; mode_b = 2'd2; req_b = 5'b10001; rdy_b = 1'b1;
    step();
    chk("n5_first", 0, {gv_b, gi_b}, {1'b1, 3'd0});
    step();
    chk("n5_grant4", 1, {gv_b, gi_b}, {1'b1, 3'd4});
    chk("n5_oh4", 1, 32'(go_b), 32'h10);
    step();
    chk("n5_wrap_idx", 2, {gv_b, gi_b}, {1'b1, 3'd0});
    chk("n5_wrap_ptr", 2, 32'(dut_b.rr_ptr_q), 32'd0);

    // Random run on N=5 against the reference model through the scoreboard.
    rst_b = 1'b1;
    model5(1'b1, 5'd0, 2'd0, 1'b0);
    step();
    for (int i = 0; i < 400; i++) begin
      rst_b  = ($urandom_range(0, 39) == 0);
      req_b  = 5'($urandom);
      if ($urandom_range(0, 3) == 0) req_b = '0;
      mode_b = 2'($urandom_range(0, 3));
      rdy_b  = 1'($urandom_range(0, 1));
      model5(rst_b, req_b, mode_b, rdy_b);
      e.v = (mv == 1); e.idx = 3'(midx); e.ptr = 3'(mptr); e.tag = i;
      e.oh = (mv == 1) ? (8'd1 << midx) : 8'd0;
      sb.push_back(e);
      step();
      if (sb.size() == 0) begin
        chk("sb_empty", i, 32'd0, 32'd1);
      end else begin
        e = sb.pop_front();
        chk("n5_rand", e.tag, {gv_b, gi_b, go_b}, {e.v, e.idx, e.oh[4:0]});
        chk("n5_range", e.tag, 32'(gi_b < 3'd5), 32'd1);
      end
    end

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
